// File: rtl/updown_counter.sv
// Up/down counter with terminal count MAX, clamped parallel load and a one-cycle boundary pulse.
// Define UPDOWN_COUNTER_SAT_EN to make the counter saturate at the boundaries instead of wrapping.
module updown_counter #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_boundary;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_q_next;

    assign w_at_max       = (r_q == MAX);
    assign w_at_zero      = (r_q == '0);
    assign tc             = en & ((up & w_at_max) | (~up & w_at_zero));
    // A load always wins, so a coincident tc never counts as a boundary event.
    assign w_boundary     = tc & ~load;
    assign w_load_clamped = (load_val > MAX) ? MAX : load_val;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = w_load_clamped;
        end else if (en) begin
            if (w_boundary) begin
`ifdef UPDOWN_COUNTER_SAT_EN
                w_q_next = r_q;
`else
                w_q_next = up ? '0 : MAX;
`endif
            end else if (up) begin
                w_q_next = r_q + 1'b1;
            end else begin
                w_q_next = r_q - 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments; the async reset clears both registers with no clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_boundary;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning counter width in bits (legal range 2..32).
REQ-002 SHALL provide parameter MAX, default 2**WIDTH-1, meaning terminal count value (legal range 1..2**WIDTH-1).
REQ-003 SHALL provide port clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL provide port en  input  1  meaning count enable.
REQ-006 SHALL provide port up  input  1  meaning direction: 1 increments, 0 decrements.
REQ-007 SHALL provide port load  input  1  meaning synchronous parallel load strobe.
REQ-008 SHALL provide port load_val  input  WIDTH  meaning value for a parallel load.
REQ-009 SHALL provide port q  output  WIDTH  meaning registered count value.
REQ-010 SHALL provide port tc  output  1  meaning combinational terminal-count flag.
REQ-011 SHALL provide port wrap  output  1  meaning registered one-cycle boundary-event pulse.

Function
REQ-012 SHALL give per-edge priority: load over en; en=0 with load=0 holds q.
REQ-013 SHALL, on load, set q to load_val; a load_val above MAX SHALL load MAX (clamp).
REQ-014 SHALL, with en=1, up=1, q<MAX, set q to q+1.
REQ-015 SHALL, with en=1, up=0, q>0, set q to q-1.
REQ-016 SHALL, with en=1, up=1, q=MAX, take the boundary action (REQ-027/028) and end at 0 (wrap build).
REQ-017 SHALL, with en=1, up=0, q=0, take the boundary action and end at MAX (wrap build).
REQ-018 SHALL drive tc = en AND ((up AND q==MAX) OR (NOT up AND q==0)); zero latency.
REQ-019 SHALL assert wrap for exactly one cycle, in the cycle after an edge where a boundary action occurred, and deassert it otherwise.
REQ-020 SHALL NOT assert wrap on a load, even when load coincides with tc=1.
REQ-021 SHALL let direction change on any cycle take effect on the same edge, with no dead cycle.
REQ-022 SHALL perform all arithmetic modulo 2**WIDTH internally; q SHALL never exceed MAX.

Reset
REQ-023 SHALL, on reset assertion, immediately (no clock needed) force q=0 and wrap=0.
REQ-024 SHALL keep q=0 and wrap=0 while reset is high, ignoring load and en.
REQ-025 SHALL resume counting on the first rising clk edge after reset deassertion.
REQ-026 SHALL abandon a pending wrap pulse when reset arrives mid-pulse; no pulse follows reset release.

Configuration
REQ-027 SHALL, when macro UPDOWN_COUNTER_SAT_EN is defined, saturate: at a boundary (REQ-016/017) q holds at MAX (up) or 0 (down), and wrap pulses on each enabled edge spent holding at the boundary.
REQ-028 SHALL, when UPDOWN_COUNTER_SAT_EN is undefined, wrap as in REQ-016/017, with one wrap pulse per wrap-around.
REQ-029 SHALL leave the ports and all other behaviour identical in both builds.

Verification
REQ-030 SHALL cover, for WIDTH=16 with default MAX: reset, then en=1 up=1 for 65536 cycles -> q steps 0..65535, then 0; one wrap pulse the cycle after the 65535->0 edge.
REQ-031 SHALL cover, for WIDTH=4, MAX=9: load 3, then down 5 edges -> q 2,1,0,9,8; tc=1 while q=0; wrap high one cycle after the 0->9 edge.
REQ-032 SHALL cover, for WIDTH=4, MAX=9: load_val=14 with load=1 en=1 -> q=9 next cycle, wrap stays 0.
REQ-033 SHALL cover, for the UPDOWN_COUNTER_SAT_EN build with WIDTH=4, MAX=9: up from 8 for 3 edges -> q 9,9,9; wrap high on each of the 2 cycles following a hold edge.
REQ-034 SHALL cover reset asserted mid-cycle with q=5 and no clock edge -> q=0 and wrap=0 immediately; first count after release gives q=1.
REQ-035 SHALL cover load=1 and en=1 with q=MAX, up=1, load_val=4 -> q=4, wrap stays 0.
